// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared widths, depth and command record for the image RAM arbiter
package ram_arb_pkg;
  localparam int AW = 20;
  localparam int DW = 24;
  localparam int DEPTH = 65536;
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          owner;
  } ram_cmd_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way grant, round-robin on contention or fixed priority to req[0]
module rr_arb2 #(
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic last;
  always_ff @(posedge clk) begin
    if (rst) last <= 1'b1;
    else if (|gnt) last <= gnt[1];
  end
  always_comb begin
    gnt[0] = req[0] & (~req[1] | FIXED_PRI | last);
    gnt[1] = req[1] & ~gnt[0];
  end
endmodule

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: shares the single-port image RAM between two requesters
module ram_access_arbiter import ram_arb_pkg::*; #(
  parameter int AW        = ram_arb_pkg::AW,
  parameter int DW        = ram_arb_pkg::DW,
  parameter int DEPTH     = ram_arb_pkg::DEPTH,
  parameter int FIXED_PRI = 0
) (
  input  logic          CK,
  input  logic          RST,
  input  logic          rq0_valid,
  output logic          rq0_ready,
  input  logic          rq0_we,
  input  logic [AW-1:0] rq0_addr,
  input  logic [DW-1:0] rq0_wdata,
  output logic          rq0_rvalid,
  output logic [DW-1:0] rq0_rdata,
  output logic          rq0_err,
  input  logic          rq1_valid,
  output logic          rq1_ready,
  input  logic          rq1_we,
  input  logic [AW-1:0] rq1_addr,
  input  logic [DW-1:0] rq1_wdata,
  output logic          rq1_rvalid,
  output logic [DW-1:0] rq1_rdata,
  output logic          rq1_err,
  output logic [AW-1:0] ram_A,
  output logic          ram_WE,
  output logic          ram_OE,
  output logic [DW-1:0] ram_D,
  input  logic [DW-1:0] ram_Q
);
  logic [1:0] gnt;
  ram_cmd_t   cmd;
  logic       in_range, go, rd_owner;
  rr_arb2 #(.FIXED_PRI(FIXED_PRI != 0)) u_arb (
    .clk(CK),
    .rst(RST),
    .req({rq1_valid, rq0_valid} & {2{~RST}}),
    .gnt(gnt)
  );
  assign rq0_ready = gnt[0];
  assign rq1_ready = gnt[1];
  always_comb begin
    cmd = gnt[1] ? ram_cmd_t'{we: rq1_we, addr: rq1_addr, wdata: rq1_wdata, owner: 1'b1}
                 : ram_cmd_t'{we: rq0_we, addr: rq0_addr, wdata: rq0_wdata, owner: 1'b0};
    in_range = {1'b0, cmd.addr} < (AW+1)'(DEPTH);
    go = |gnt & in_range;
  end
  // rd_owner tags the read on the bus so its data returns only to the issuer
  always_ff @(posedge CK) begin
    if (RST) begin
      ram_A      <= '0;
      ram_D      <= '0;
      ram_WE     <= 1'b0;
      ram_OE     <= 1'b0;
      rd_owner   <= 1'b0;
      rq0_err    <= 1'b0;
      rq1_err    <= 1'b0;
      rq0_rvalid <= 1'b0;
      rq1_rvalid <= 1'b0;
      rq0_rdata  <= '0;
      rq1_rdata  <= '0;
    end else begin
      ram_WE     <= go & cmd.we;
      ram_OE     <= go & ~cmd.we;
      if (go) begin
        ram_A    <= cmd.addr;
        ram_D    <= cmd.wdata;
        rd_owner <= cmd.owner;
      end
      rq0_err    <= gnt[0] & ~in_range;
      rq1_err    <= gnt[1] & ~in_range;
      rq0_rvalid <= ram_OE & ~rd_owner;
      rq1_rvalid <= ram_OE & rd_owner;
      if (ram_OE & ~rd_owner) rq0_rdata <= ram_Q;
      if (ram_OE & rd_owner) rq1_rdata <= ram_Q;
    end
  end
endmodule
